// File: rtl/rv32i_program_encoder.sv
// Streaming RV32I (+M subset) instruction encoder: packs decoded-field requests into
// 32-bit words and writes them to consecutive imem word addresses, flagging unencodable requests.
module rv32i_program_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [3:0]        in_alu_ops,
    input  logic [1:0]        in_mem_width,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err,
    output logic [2:0]        err_code
);
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   CAP    = {1'b1, {ADDR_W{1'b0}}};

    // Returns {err_code, word}; err_code is 0 when the request is representable.
    function automatic logic [34:0] encode(
        input logic [2:0]  cls,
        input logic [3:0]  op,
        input logic [1:0]  w,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [4:0]  rd,
        input logic [31:0] imm
    );
        logic [2:0]  ec;
        logic [31:0] word;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [2:0]  bf3;
        logic        op_ok, br_ok, is_m, is_sub, is_shift, s12, s13, s21;
        ec = 3'd0; word = 32'd0; f3 = 3'b000; f7 = 7'b0000000; bf3 = 3'b000;
        op_ok = 1'b1; br_ok = 1'b1; is_m = 1'b0; is_sub = 1'b0; is_shift = 1'b0;
        case (op)
            4'b0000: f3 = 3'b000;
            4'b0001: begin f3 = 3'b000; f7 = 7'b0100000; is_sub = 1'b1; end
            4'b0010: f3 = 3'b100;
            4'b0011: f3 = 3'b110;
            4'b0100: f3 = 3'b111;
            4'b0101: begin f3 = 3'b001; is_shift = 1'b1; end
            4'b0110: begin f3 = 3'b101; is_shift = 1'b1; end
            4'b1000: begin f3 = 3'b101; f7 = 7'b0100000; is_shift = 1'b1; end
            4'b1001: f3 = 3'b010;
            4'b1011: f3 = 3'b011;
            4'b1100: begin f3 = 3'b000; f7 = 7'b0000001; is_m = 1'b1; end
            4'b1101: begin f3 = 3'b100; f7 = 7'b0000001; is_m = 1'b1; end
            4'b1110: begin f3 = 3'b110; f7 = 7'b0000001; is_m = 1'b1; end
            default: op_ok = 1'b0;
        endcase
        case (op)
            4'b0000: bf3 = 3'b000;
            4'b0001: bf3 = 3'b001;
            4'b0010: bf3 = 3'b100;
            4'b0011: bf3 = 3'b101;
            4'b0100: bf3 = 3'b110;
            4'b0101: bf3 = 3'b111;
            default: br_ok = 1'b0;
        endcase
        s12 = (imm[31:11] == {21{imm[11]}});
        s13 = (imm[31:12] == {20{imm[12]}}) && !imm[0];
        s21 = (imm[31:20] == {12{imm[20]}}) && !imm[0];
        case (cls)
            3'd0: begin
                if (!op_ok) ec = 3'd1;
                else word = {f7, rs2, rs1, f3, rd, OPC_R};
            end
            3'd1: begin
                if (!op_ok || is_m || is_sub) ec = 3'd1;
                else if (is_shift) begin
                    if (imm[31:5] != 27'd0) ec = 3'd2;
                    else word = {f7, imm[4:0], rs1, f3, rd, OPC_IMM};
                end
                else if (!s12) ec = 3'd2;
                else word = {imm[11:0], rs1, f3, rd, OPC_IMM};
            end
            3'd2: begin
                if (w == 2'b11) ec = 3'd3;
                else if (!s12) ec = 3'd2;
                else word = {imm[11:0], rs1, 1'b0, w, rd, OPC_LOAD};
            end
            3'd3: begin
                if (w == 2'b11) ec = 3'd3;
                else if (!s12) ec = 3'd2;
                else word = {imm[11:5], rs2, rs1, 1'b0, w, imm[4:0], OPC_STORE};
            end
            3'd4: begin
                if (!br_ok) ec = 3'd1;
                else if (!s13) ec = 3'd2;
                else word = {imm[12], imm[10:5], rs2, rs1, bf3, imm[4:1], imm[11], OPC_BRANCH};
            end
            3'd5: begin
                if (!s21) ec = 3'd2;
                else word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            end
            3'd6: begin
                if (!s12) ec = 3'd2;
                else word = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
            end
            default: begin
                if (imm[11:0] != 12'd0) ec = 3'd2;
                else word = {imm[31:12], rd, OPC_LUI};
            end
        endcase
        return {ec, word};
    endfunction

    logic              we_d, we_q, last_d, last_q, done_d, done_q, err_d, err_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [31:0]       wdata_d, wdata_q;
    logic [ADDR_W:0]   count_d, count_q;
    logic [2:0]        err_code_d, err_code_q;
    logic [34:0]       enc;
    logic [2:0]        new_err;
    logic              hs, accept;

    assign in_ready   = !we_q || imem_ready;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

    // Next-state: retire the pending write first, then consider a newly accepted request.
    always_comb begin
        enc        = encode(in_class, in_alu_ops, in_mem_width, in_rs1, in_rs2, in_rd, in_imm);
        hs         = we_q && imem_ready;
        accept     = in_valid && in_ready;
        new_err    = 3'd0;
        we_d       = we_q;
        last_d     = last_q;
        done_d     = 1'b0;
        err_d      = err_q;
        err_code_d = err_code_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        count_d    = count_q;
        if (clr) begin
            we_d = 1'b0; last_d = 1'b0; err_d = 1'b0; err_code_d = 3'd0;
            addr_d = BASE_A; count_d = '0;
        end else begin
            if (hs) begin
                we_d = 1'b0;
                if (last_q) begin
                    addr_d = BASE_A; count_d = '0; done_d = 1'b1;
                end else begin
                    addr_d = addr_q + ADDR_W'(1); count_d = count_q + (ADDR_W+1)'(1);
                end
            end else begin
                we_d = we_q;
            end
            if (accept) begin
                if (enc[34:32] != 3'd0) new_err = enc[34:32];
                else if (count_d >= CAP) new_err = 3'd4;
                else new_err = 3'd0;
                if (new_err == 3'd0) begin
                    we_d = 1'b1; wdata_d = enc[31:0]; last_d = in_last;
                end else begin
                    err_d = 1'b1;
                    err_code_d = (err_code_q == 3'd0) ? new_err : err_code_q;
                    // An unencodable final request still ends the program.
                    if (in_last) begin
                        done_d = 1'b1; addr_d = BASE_A; count_d = '0;
                    end else begin
                        done_d = done_d;
                    end
                end
            end else begin
                new_err = 3'd0;
            end
        end
    end

    // State and registered output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q <= 1'b0; last_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
            err_code_q <= 3'd0; addr_q <= BASE_A; wdata_q <= 32'd0; count_q <= '0;
        end else begin
            we_q <= we_d; last_q <= last_d; done_q <= done_d; err_q <= err_d;
            err_code_q <= err_code_d; addr_q <= addr_d; wdata_q <= wdata_d; count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_rv32i_program_encoder.sv
// Directed self-checking bench for rv32i_program_encoder (default size plus a 4-word instance).
module tb_rv32i_program_encoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr, in_valid, imem_ready, in_last;
    logic [2:0]  in_class;
    logic [3:0]  in_alu_ops;
    logic [1:0]  in_mem_width;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_imm;
    logic        in_ready, imem_we, done, err;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [10:0] count;
    logic [2:0]  err_code;

    logic        s_rst, s_clr, s_valid, s_imem_ready;
    logic        s_in_ready, s_we, s_done, s_err;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_count, s_code;

    int n_checks = 0;
    int n_fail   = 0;

    rv32i_program_encoder #(.ADDR_W(10), .BASE_ADDR(0)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_alu_ops(in_alu_ops), .in_mem_width(in_mem_width),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm), .in_last(in_last),
        .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .done(done), .err(err), .err_code(err_code)
    );

    rv32i_program_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
        .clk(clk), .rst(s_rst), .clr(s_clr), .in_valid(s_valid), .in_ready(s_in_ready),
        .in_class(in_class), .in_alu_ops(in_alu_ops), .in_mem_width(in_mem_width),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm), .in_last(in_last),
        .imem_we(s_we), .imem_ready(s_imem_ready), .imem_addr(s_addr), .imem_wdata(s_wdata),
        .count(s_count), .done(s_done), .err(s_err), .err_code(s_code)
    );

    task automatic set_req(input logic [2:0] c, input logic [3:0] op, input logic [1:0] w,
                           input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                           input logic [31:0] imm, input logic last);
        in_class = c; in_alu_ops = op; in_mem_width = w;
        in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_imm = imm; in_last = last;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request on the main DUT and return 1ns after the accepting edge.
    task automatic send(input logic [2:0] c, input logic [3:0] op, input logic [1:0] w,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input logic [31:0] imm, input logic last);
        int n;
        set_req(c, op, w, r1, r2, rd, imm, last);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin step(); n++; end
        n_checks++;
        if (!in_ready) begin n_fail++; $display("FAIL send_timeout: in_ready got %b required 1", in_ready); end
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_rst = 1'b1;
        step(); step();
        n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b required 0", imem_we); end
        n_checks++; if (imem_addr !== 10'd0) begin n_fail++; $display("FAIL rst_addr: got %0d required 0", imem_addr); end
        n_checks++; if (imem_wdata !== 32'd0) begin n_fail++; $display("FAIL rst_wdata: got %h required 0", imem_wdata); end
        n_checks++; if (count !== 11'd0) begin n_fail++; $display("FAIL rst_count: got %0d required 0", count); end
        n_checks++; if ({done, err, err_code} !== 5'd0) begin n_fail++; $display("FAIL rst_flags: got %b required 00000", {done, err, err_code}); end
        rst = 1'b0; s_rst = 1'b0;
        step();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_r_encode();
        send(3'd0, 4'b0000, 2'b00, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
        n_checks++; if (imem_wdata !== 32'h002081B3) begin n_fail++; $display("FAIL add_wdata: got %h required 002081B3", imem_wdata); end
        n_checks++; if (imem_addr !== 10'd0 || imem_we !== 1'b1) begin n_fail++; $display("FAIL add_addr: got %0d/%b required 0/1", imem_addr, imem_we); end
        send(3'd0, 4'b1100, 2'b00, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
        n_checks++; if (imem_wdata !== 32'h022081B3) begin n_fail++; $display("FAIL mul_wdata: got %h required 022081B3", imem_wdata); end
        n_checks++; if (imem_addr !== 10'd1) begin n_fail++; $display("FAIL mul_addr: got %0d required 1", imem_addr); end
        step();
        n_checks++; if (count !== 11'd2 || imem_we !== 1'b0) begin n_fail++; $display("FAIL r_count: got %0d/%b required 2/0", count, imem_we); end
    endtask

    task automatic test_imm_classes();
        send(3'd1, 4'b0000, 2'b00, 5'd0, 5'd0, 5'd1, 32'd5, 1'b0);
        n_checks++; if (imem_wdata !== 32'h00500093) begin n_fail++; $display("FAIL addi_wdata: got %h required 00500093", imem_wdata); end
        send(3'd3, 4'b0000, 2'b10, 5'd1, 5'd2, 5'd0, 32'd8, 1'b0);
        n_checks++; if (imem_wdata !== 32'h0020A423) begin n_fail++; $display("FAIL sw_wdata: got %h required 0020A423", imem_wdata); end
        send(3'd7, 4'b0000, 2'b00, 5'd0, 5'd0, 5'd5, 32'h12345000, 1'b0);
        n_checks++; if (imem_wdata !== 32'h123452B7 || imem_addr !== 10'd4) begin n_fail++; $display("FAIL lui_wdata: got %h@%0d required 123452B7@4", imem_wdata, imem_addr); end
        send(3'd1, 4'b1000, 2'b00, 5'd1, 5'd0, 5'd2, 32'd31, 1'b0);
        n_checks++; if (imem_wdata !== 32'h41F0D113) begin n_fail++; $display("FAIL srai_wdata: got %h required 41F0D113", imem_wdata); end
        step();
        n_checks++; if (count !== 11'd6) begin n_fail++; $display("FAIL imm_count: got %0d required 6", count); end
    endtask

    task automatic test_control_flow();
        send(3'd4, 4'b0000, 2'b00, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 1'b0);
        n_checks++; if (imem_wdata !== 32'hFE208EE3) begin n_fail++; $display("FAIL beq_wdata: got %h required FE208EE3", imem_wdata); end
        send(3'd5, 4'b0000, 2'b00, 5'd0, 5'd0, 5'd1, 32'd8, 1'b1);
        n_checks++; if (imem_wdata !== 32'h008000EF || imem_addr !== 10'd7) begin n_fail++; $display("FAIL jal_wdata: got %h@%0d required 008000EF@7", imem_wdata, imem_addr); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_early: got %b required 0", done); end
        step();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_pulse: got %b required 1", done); end
        n_checks++; if (imem_addr !== 10'd0 || count !== 11'd0) begin n_fail++; $display("FAIL done_rewind: got %0d/%0d required 0/0", imem_addr, count); end
        step();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_width: got %b required 0", done); end
    endtask

    task automatic test_errors();
        send(3'd1, 4'b0000, 2'b00, 5'd0, 5'd0, 5'd1, 32'd2048, 1'b0);
        n_checks++; if (imem_we !== 1'b0 || err !== 1'b1 || err_code !== 3'd2) begin n_fail++; $display("FAIL addi_range: got we=%b err=%b code=%0d required 0/1/2", imem_we, err, err_code); end
        send(3'd4, 4'b0111, 2'b00, 5'd1, 5'd2, 5'd0, 32'd4, 1'b0);
        n_checks++; if (err_code !== 3'd2 || imem_we !== 1'b0) begin n_fail++; $display("FAIL code_sticky: got %0d/%b required 2/0", err_code, imem_we); end
        clr = 1'b1; step(); clr = 1'b0;
        n_checks++; if (err !== 1'b0 || err_code !== 3'd0) begin n_fail++; $display("FAIL clr_err: got %b/%0d required 0/0", err, err_code); end
        send(3'd1, 4'b0000, 2'b00, 5'd0, 5'd0, 5'd1, 32'd2048, 1'b1);
        n_checks++; if (done !== 1'b1 || err_code !== 3'd2) begin n_fail++; $display("FAIL err_last_done: got %b/%0d required 1/2", done, err_code); end
        clr = 1'b1; step(); clr = 1'b0;
        send(3'd2, 4'b0000, 2'b11, 5'd1, 5'd0, 5'd2, 32'd0, 1'b0);
        n_checks++; if (err_code !== 3'd3 || count !== 11'd0) begin n_fail++; $display("FAIL bad_width: got %0d/%0d required 3/0", err_code, count); end
        clr = 1'b1; step(); clr = 1'b0;
    endtask

    task automatic test_backpressure();
        imem_ready = 1'b0;
        send(3'd0, 4'b0000, 2'b00, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
        set_req(3'd0, 4'b1100, 2'b00, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (in_ready !== 1'b0 || imem_we !== 1'b1 || imem_wdata !== 32'h002081B3 || imem_addr !== 10'd0) begin
                n_fail++; $display("FAIL bp_hold%0d: got rdy=%b we=%b %h@%0d required 0/1 002081B3@0", i, in_ready, imem_we, imem_wdata, imem_addr);
            end
            step();
        end
        imem_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: in_ready got %b required 1", in_ready); end
        step();
        in_valid = 1'b0;
        n_checks++; if (imem_we !== 1'b1 || imem_wdata !== 32'h022081B3 || imem_addr !== 10'd1) begin n_fail++; $display("FAIL bp_second: got %b %h@%0d required 1 022081B3@1", imem_we, imem_wdata, imem_addr); end
        step();
        n_checks++; if (imem_we !== 1'b0 || count !== 11'd2) begin n_fail++; $display("FAIL bp_count: got %b/%0d required 0/2", imem_we, count); end
    endtask

    task automatic test_overflow();
        set_req(3'd0, 4'b0000, 2'b00, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (s_we !== 1'b1 || s_addr !== i[1:0]) begin n_fail++; $display("FAIL ovf_write%0d: got %b@%0d required 1@%0d", i, s_we, s_addr, i); end
        end
        step();
        s_valid = 1'b0;
        n_checks++; if (s_we !== 1'b0 || s_err !== 1'b1 || s_code !== 3'd4 || s_count !== 3'd4) begin n_fail++; $display("FAIL ovf_err: got we=%b err=%b code=%0d cnt=%0d required 0/1/4/4", s_we, s_err, s_code, s_count); end
        s_clr = 1'b1; step(); s_clr = 1'b0;
        s_imem_ready = 1'b0; s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        n_checks++; if (s_we !== 1'b1 || s_addr !== 2'd0) begin n_fail++; $display("FAIL rst_pending: got %b@%0d required 1@0", s_we, s_addr); end
        #2 s_rst = 1'b1;
        #1;
        n_checks++; if (s_we !== 1'b0) begin n_fail++; $display("FAIL rst_drop: got %b required 0", s_we); end
        s_rst = 1'b0;
        s_imem_ready = 1'b1;
    endtask

    initial begin
        clr = 1'b0; in_valid = 1'b0; imem_ready = 1'b1;
        s_clr = 1'b0; s_valid = 1'b0; s_imem_ready = 1'b1;
        rst = 1'b1; s_rst = 1'b1;
        set_req(3'd0, 4'b0000, 2'b00, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        test_reset();
        test_r_encode();
        test_imm_classes();
        test_control_flow();
        test_errors();
        test_backpressure();
        test_overflow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
